// File: rtl/lfsr_rand_fifo_pkg.sv
// Shared types and constants for the LFSR random-word FIFO.
// Bytes from the LFSR are packed into 32-bit words before they are stored.
package lfsr_rand_fifo_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_WIDTH     = 32;

   typedef enum logic {
      FILL,
      HOLD
   } state_t;

endpackage

// File: rtl/lfsr_word_ram.sv
// Word storage: DEPTH x 32, one write port and a registered read port.
// A read and a write to the same address return the old contents.
module lfsr_word_ram
   import lfsr_rand_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [WORD_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [WORD_WIDTH-1:0] rd_data
);

   logic [WORD_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Output register keeps its value between reads.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/lfsr_rand_fifo.sv
// Packs successive LFSR bytes into 32-bit words and queues them in a FIFO.
// The LFSR is only advanced while a word is being collected and space can follow.
module lfsr_rand_fifo
   import lfsr_rand_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             lfsr_data,
   input  logic                   new_seed,
   output logic                   lfsr_enable,
   input  logic                   rd_req,
   output logic [31:0]            rd_data,
   output logic                   rd_valid,
   output logic                   rd_underflow,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   state_t                state;
   logic [2:0]            req_cnt;
   logic [1:0]            byte_cnt;
   logic                  cap_valid;
   logic                  rst_done;
   logic [WORD_WIDTH-1:0] word;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         cnt;

   logic                  pop;
   logic                  room;
   logic                  last_cap;
   logic                  wr_en;
   logic [WORD_WIDTH-1:0] full_word;
   logic [WORD_WIDTH-1:0] wr_data;

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign count = cnt;

   // rst_done keeps the enable low in the cycle the LFSR leaves its own reset.
   assign lfsr_enable = reset_n && rst_done && (state == FILL) &&
                        (req_cnt < 3'(BYTES_PER_WORD)) && !new_seed;

   assign pop       = rd_req && !empty && !new_seed;
   assign room      = !full || pop;
   assign last_cap  = cap_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
   assign full_word = {lfsr_data, word[23:0]};
   assign wr_en     = reset_n && !new_seed &&
                      (((state == FILL) && last_cap && room) || ((state == HOLD) && room));
   assign wr_data   = (state == HOLD) ? word : full_word;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= FILL;
         req_cnt      <= '0;
         byte_cnt     <= '0;
         cap_valid    <= 1'b0;
         rst_done     <= 1'b0;
         word         <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt          <= '0;
         rd_valid     <= 1'b0;
         rd_underflow <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (new_seed) begin
            state        <= FILL;
            req_cnt      <= '0;
            byte_cnt     <= '0;
            cap_valid    <= 1'b0;
            word         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            rd_valid     <= 1'b0;
            rd_underflow <= 1'b0;
         end else begin
            rd_valid     <= pop;
            rd_underflow <= rd_req && empty;
            cap_valid    <= lfsr_enable;
            if (lfsr_enable) begin
               req_cnt <= req_cnt + 1'b1;
            end
            if (wr_en) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(wr_en) - CW'(pop);

            unique case (state)
               FILL: begin
                  if (last_cap) begin
                     req_cnt  <= '0;
                     byte_cnt <= '0;
                     if (!room) begin
                        word  <= full_word;
                        state <= HOLD;
                     end
                  end else if (cap_valid) begin
                     word[{byte_cnt, 3'b000} +: 8] <= lfsr_data;
                     byte_cnt                      <= byte_cnt + 1'b1;
                  end
               end
               HOLD: begin
                  if (room) begin
                     state <= FILL;
                  end
               end
            endcase
         end
      end
   end

   lfsr_word_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_lfsr_rand_fifo.sv
// Bench for lfsr_rand_fifo; a behavioural model of the upstream 8-bit XNOR LFSR
// (reset value 0x01, taps 7,5,4,3) feeds lfsr_data and shares new_seed/seed.
module tb_lfsr_rand_fifo;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        new_seed = 1'b0;
   logic [7:0]  seed = 8'h00;
   logic        rd_req = 1'b0;
   logic [7:0]  lfsr_data;
   logic        lfsr_enable;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_underflow;
   logic        empty;
   logic        full;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   logic [31:0] words [0:2099];
   logic [31:0] seed_words [0:3];

   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], ~(v[7] ^ v[5] ^ v[4] ^ v[3])};
   endfunction

   always @(posedge clk) begin
      if (!reset_n)         lfsr_data <= 8'h01;
      else if (new_seed)    lfsr_data <= seed;
      else if (lfsr_enable) lfsr_data <= lfsr_next(lfsr_data);
   end

   lfsr_rand_fifo #(
      .DEPTH (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .lfsr_data    (lfsr_data),
      .new_seed     (new_seed),
      .lfsr_enable  (lfsr_enable),
      .rd_req       (rd_req),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_underflow (rd_underflow),
      .empty        (empty),
      .full         (full),
      .count        (count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      new_seed = 1'b0;
      rd_req   = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic wait_count(input int target, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (count == 3'(target)) begin
            ok = 1'b1;
            return;
         end
         step();
      end
      ok = (count == 3'(target));
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rd_req  = 1'b1;
      step();
      step();
      checks += 7;
      if (count !== 3'd0)        begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      if (empty !== 1'b1)        begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      if (full !== 1'b0)         begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      if (rd_valid !== 1'b0)     begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      if (rd_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", rd_underflow); end
      if (rd_data !== 32'h0)     begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      if (lfsr_enable !== 1'b0)  begin errors++; $display("FAIL reset_enable: got %b want 0", lfsr_enable); end
      rd_req  = 1'b0;
      reset_n = 1'b1;
      #1;
      checks++;
      if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL release_enable: got %b want 0", lfsr_enable); end
      step();
      checks++;
      if (lfsr_enable !== 1'b1) begin errors++; $display("FAIL post_release_enable: got %b want 1", lfsr_enable); end
   endtask

   task automatic test_first_words();
      bit ok;
      do_reset();
      wait_count(2, 30, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL first_words_wait: count=%0d want 2", count); end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      checks += 2;
      if (rd_valid !== 1'b1)         begin errors++; $display("FAIL pop0_valid: got %b want 1", rd_valid); end
      if (rd_data !== 32'h1E0F0703)  begin errors++; $display("FAIL pop0_data: got %h want 1e0f0703", rd_data); end
      step();
      checks += 2;
      if (rd_valid !== 1'b0)         begin errors++; $display("FAIL idle_valid: got %b want 0", rd_valid); end
      if (rd_data !== 32'h1E0F0703)  begin errors++; $display("FAIL hold_data: got %h want 1e0f0703", rd_data); end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      checks += 2;
      if (rd_valid !== 1'b1)         begin errors++; $display("FAIL pop1_valid: got %b want 1", rd_valid); end
      if (rd_data !== 32'hE8F47A3D)  begin errors++; $display("FAIL pop1_data: got %h want e8f47a3d", rd_data); end
   endtask

   task automatic test_full_hold();
      bit ok;
      bit saw_en;
      do_reset();
      wait_count(4, 40, ok);
      checks += 2;
      if (!ok)           begin errors++; $display("FAIL full_wait: count=%0d want 4", count); end
      if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
      repeat (10) step();
      saw_en = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (lfsr_enable !== 1'b0) saw_en = 1'b1;
         step();
      end
      checks += 2;
      if (saw_en)         begin errors++; $display("FAIL hold_enable: got 1 want 0 over 50 cycles"); end
      if (count !== 3'd4) begin errors++; $display("FAIL hold_count: got %0d want 4", count); end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      checks += 4;
      if (rd_data !== words[0])  begin errors++; $display("FAIL hold_pop_data: got %h want %h", rd_data, words[0]); end
      if (count !== 3'd4)        begin errors++; $display("FAIL hold_pop_count: got %0d want 4", count); end
      if (full !== 1'b1)         begin errors++; $display("FAIL hold_pop_full: got %b want 1", full); end
      if (lfsr_enable !== 1'b1)  begin errors++; $display("FAIL refill_enable: got %b want 1", lfsr_enable); end
      for (int k = 1; k <= 4; k++) begin
         step();
         rd_req = 1'b1;
         step();
         rd_req = 1'b0;
         checks++;
         if (rd_data !== words[k]) begin
            errors++;
            $display("FAIL drain_data[%0d]: got %h want %h", k, rd_data, words[k]);
         end
      end
   endtask

   task automatic test_underflow_stream();
      int idx;
      int last;
      do_reset();
      rd_req = 1'b1;
      idx    = 0;
      last   = 0;
      for (int cyc = 0; cyc < 42; cyc++) begin
         step();
         checks += 2;
         if ((rd_valid ^ rd_underflow) !== 1'b1) begin
            errors++;
            $display("FAIL stream_pulse[%0d]: valid=%b underflow=%b want exactly one", cyc, rd_valid,
                     rd_underflow);
         end
         if (count > 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want <=1", cyc, count); end
         if (cyc == 0) begin
            checks++;
            if (rd_underflow !== 1'b1) begin errors++; $display("FAIL first_underflow: got %b want 1", rd_underflow); end
         end
         if (rd_valid === 1'b1) begin
            checks++;
            if (rd_data !== words[idx]) begin
               errors++;
               $display("FAIL stream_data[%0d]: got %h want %h", idx, rd_data, words[idx]);
            end
            if (idx > 0) begin
               checks++;
               if (cyc - last != 5) begin errors++; $display("FAIL stream_gap: got %0d want 5", cyc - last); end
            end
            last = cyc;
            idx++;
         end
      end
      rd_req = 1'b0;
      checks++;
      if (idx != 8) begin errors++; $display("FAIL stream_words: got %0d want 8", idx); end
   endtask

   task automatic test_new_seed();
      bit ok;
      do_reset();
      wait_count(2, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL seed_wait: count=%0d want 2", count); end
      step();
      step();
      new_seed = 1'b1;
      seed     = 8'h55;
      rd_req   = 1'b1;
      #1;
      checks++;
      if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL seed_enable: got %b want 0", lfsr_enable); end
      step();
      new_seed = 1'b0;
      rd_req   = 1'b0;
      checks += 4;
      if (count !== 3'd0)        begin errors++; $display("FAIL seed_count: got %0d want 0", count); end
      if (empty !== 1'b1)        begin errors++; $display("FAIL seed_empty: got %b want 1", empty); end
      if (rd_valid !== 1'b0)     begin errors++; $display("FAIL seed_rd_valid: got %b want 0", rd_valid); end
      if (rd_underflow !== 1'b0) begin errors++; $display("FAIL seed_underflow: got %b want 0", rd_underflow); end
      wait_count(1, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL seed_word_wait: count=%0d want 1", count); end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      checks += 2;
      if (rd_data[7:0] !== 8'hAA)     begin errors++; $display("FAIL seed_byte0: got %h want aa", rd_data[7:0]); end
      if (rd_data !== seed_words[0])  begin errors++; $display("FAIL seed_word: got %h want %h", rd_data, seed_words[0]); end
   endtask

   task automatic test_reset_in_hold();
      bit ok;
      do_reset();
      wait_count(4, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rh_wait: count=%0d want 4", count); end
      repeat (10) step();
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      checks++;
      if (rd_data !== words[0]) begin errors++; $display("FAIL rh_pop: got %h want %h", rd_data, words[0]); end
      repeat (10) step();
      checks += 2;
      if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL rh_hold_enable: got %b want 0", lfsr_enable); end
      if (count !== 3'd4)       begin errors++; $display("FAIL rh_count: got %0d want 4", count); end
      reset_n = 1'b0;
      step();
      checks += 6;
      if (count !== 3'd0)        begin errors++; $display("FAIL rh_reset_count: got %0d want 0", count); end
      if (empty !== 1'b1)        begin errors++; $display("FAIL rh_reset_empty: got %b want 1", empty); end
      if (full !== 1'b0)         begin errors++; $display("FAIL rh_reset_full: got %b want 0", full); end
      if (rd_data !== 32'h0)     begin errors++; $display("FAIL rh_reset_data: got %h want 0", rd_data); end
      if (rd_valid !== 1'b0)     begin errors++; $display("FAIL rh_reset_valid: got %b want 0", rd_valid); end
      if (lfsr_enable !== 1'b0)  begin errors++; $display("FAIL rh_reset_enable: got %b want 0", lfsr_enable); end
      reset_n = 1'b1;
      #1;
      checks++;
      if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL rh_release_enable: got %b want 0", lfsr_enable); end
      wait_count(1, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rh_word_wait: count=%0d want 1", count); end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      checks++;
      if (rd_data !== 32'h1E0F0703) begin errors++; $display("FAIL rh_first_word: got %h want 1e0f0703", rd_data); end
   endtask

   task automatic test_random();
      int idx;
      do_reset();
      idx = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         rd_req = 1'($urandom_range(0, 1));
         step();
         checks += 2;
         if ((rd_valid ^ rd_underflow) !== rd_req) begin
            errors++;
            $display("FAIL rand_pulse[%0d]: valid=%b underflow=%b req=%b", cyc, rd_valid, rd_underflow,
                     rd_req);
         end
         if (count > 3'd4) begin errors++; $display("FAIL rand_count[%0d]: got %0d want <=4", cyc, count); end
         if (rd_valid === 1'b1) begin
            checks++;
            if (rd_data !== words[idx]) begin
               errors++;
               $display("FAIL rand_data[%0d]: got %h want %h", idx, rd_data, words[idx]);
            end
            if (idx < 2099) idx++;
         end
      end
      rd_req = 1'b0;
      checks++;
      if (idx < 1800) begin errors++; $display("FAIL rand_throughput: got %0d words want >=1800", idx); end
   endtask

   initial begin
      logic [7:0] s;
      s = 8'h01;
      for (int i = 0; i < 2100; i++) begin
         for (int b = 0; b < 4; b++) begin
            s = lfsr_next(s);
            words[i][8*b +: 8] = s;
         end
      end
      s = 8'h55;
      for (int i = 0; i < 4; i++) begin
         for (int b = 0; b < 4; b++) begin
            s = lfsr_next(s);
            seed_words[i][8*b +: 8] = s;
         end
      end

      test_reset();
      test_first_words();
      test_full_hold();
      test_underflow_stream();
      test_new_seed();
      test_reset_in_hold();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/lfsr_rand_fifo.md
LFSR_RAND_FIFO -- requirements
Module: lfsr_rand_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in 32-bit words (power of 2, >=2).
REQ-002 SHALL have ports: clk  input  1  clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 lfsr_data  input  8  current byte from the upstream LFSR stage.
REQ-005 new_seed  input  1  the same seed-load strobe delivered to the LFSR; acts as a flush here.
REQ-006 lfsr_enable  output  1  advance request to the LFSR enable input; combinational from registered state.
REQ-007 rd_req  input  1  pop request from the consumer.
REQ-008 rd_data  output  32  popped word, registered.
REQ-009 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-010 rd_underflow  output  1  one-cycle pulse when rd_req arrives while empty.
REQ-011 empty / full  output  1 each  FIFO word count ==0 / ==DEPTH.
REQ-012 count  output  $clog2(DEPTH)+1  stored word count.

Function
REQ-013 SHALL use states FILL (collecting bytes) and HOLD (word complete, FIFO full).
REQ-014 lfsr_enable = (state==FILL) && req_cnt<4 && !new_seed; req_cnt counts enables issued for the current word.
REQ-015 SHALL register lfsr_enable as cap_valid and capture lfsr_data when cap_valid==1, so the byte sampled is the LFSR value one cycle after its enable.
REQ-016 Packing order: 1st captured byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-017 On the 4th capture: if FIFO has room (count<DEPTH, or count==DEPTH with a pop that cycle), write word at that edge, clear req_cnt/byte_cnt, stay FILL; else move to HOLD holding the word.
REQ-018 HOLD: lfsr_enable=0; write held word at the first edge where room exists (same-cycle pop counts), then return to FILL.
REQ-019 Steady-state throughput: 1 word per 5 cycles (4 enable cycles + 1 commit cycle).
REQ-020 Pop: rd_req && !empty -> rd_data = oldest word, rd_valid=1 on the following cycle; read latency 1.
REQ-021 rd_req && empty -> no pop, rd_valid=0, rd_underflow=1 next cycle; count unchanged.
REQ-022 Simultaneous write and pop: count unchanged; pop returns the oldest word, never the word being written unless count was 0 (then pop is an underflow).
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-024 new_seed=1: next edge clears FIFO (count=0, pointers 0), partial word, req_cnt, byte_cnt, cap_valid, state=FILL; rd_req that cycle ignored (no rd_valid, no underflow); new_seed has priority over everything except reset.
REQ-025 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-026 reset_n=0 at a clock edge: state=FILL, count=0, pointers=0, req_cnt=byte_cnt=0, cap_valid=0, rd_data=0, rd_valid=0, rd_underflow=0; hence empty=1, full=0.
REQ-027 lfsr_enable SHALL be 0 while reset_n=0 and in the cycle of reset release, so no enable overlaps the LFSR's own reset.
REQ-028 Reset mid-word or in HOLD SHALL discard all partial and stored data.

Structure
REQ-029 A shared package SHALL hold the state enum (FILL, HOLD), BYTES_PER_WORD=4, and the word width of 32.
REQ-030 Storage SHALL be one sub-module, lfsr_word_ram (DEPTH x 32, single write port, registered read port); packer and control stay in lfsr_rand_fifo.

Verification (bench drives clk and reset_n and instantiates the existing LFSR stage alorium_lfsr downstream-connected: lfsr_enable->enable, shared new_seed/seed)
REQ-031 Reset, no reads for 10 cycles -> first FIFO word 0x1E0F0703, second 0xE8F47A3D; pops in order return those values with rd_valid 1 cycle after rd_req.
REQ-032 No reads until full (DEPTH=4) -> count=4, full=1, 5th word in HOLD, lfsr_enable=0 for 50 cycles; one pop -> held word written at that edge, count stays 4.
REQ-033 rd_req every cycle from reset -> rd_underflow pulses while empty, no rd_valid without data, one word per 5 cycles sustained.
REQ-034 new_seed with seed=0x55 during 3rd byte of a word with count=2 -> count=0, empty=1 next cycle; next word's first byte is the LFSR value after one shift from 0x55, i.e. 0xAA.
REQ-035 reset_n low for 1 cycle while in HOLD with count=4 -> all outputs at reset values, first post-reset word again 0x1E0F0703.
REQ-036 Random rd_req (50%) over 10,000 cycles against a reference model: no loss, duplication or reordering; count always in 0..4.
